// File: rtl/mcs_line_bridge.sv
// mcs_line_bridge: bridges 32-bit MicroBlaze MCS IO bus accesses onto the
// 256-bit DDR3 controller line port.
//
// Writes are combined into a single line buffer (with per-byte valid bits) and
// pushed out as one masked line write, either when a different line is needed
// or after FLUSH_IDLE idle cycles. Reads are served from a one-line cache that
// is filled with a full line read on a miss. The cache is kept coherent with
// the write buffer by merging written bytes into it whenever it holds the same
// line.
module mcs_line_bridge #(
    parameter int unsigned FLUSH_IDLE = 64
) (
    input  logic         clk,
    input  logic         rst,
    // MCS IO bus
    input  logic         IO_Addr_Strobe,
    input  logic         IO_Read_Strobe,
    input  logic         IO_Write_Strobe,
    input  logic [31:0]  IO_Address,
    input  logic [3:0]   IO_Byte_Enable,
    input  logic [31:0]  IO_Write_Data,
    output logic [31:0]  IO_Read_Data,
    output logic         IO_Ready,
    input  logic [3:0]   page,
    // DDR3 controller line port
    output logic         srd,
    output logic         swr,
    output logic [28:0]  sa,
    output logic [255:0] swdat,
    output logic [31:0]  smsk,
    input  logic [255:0] srdat,
    input  logic         srdy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_FILL  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Merge the enabled bytes of one 32-bit word into a 256-bit line.
    function automatic logic [255:0] merge_line(
        input logic [255:0] line,
        input logic [2:0]   word,
        input logic [3:0]   be,
        input logic [31:0]  data
    );
        logic [255:0] r;
        r = line;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                r[32*int'(word) + 8*k +: 8] = data[8*k +: 8];
            end
        end
        return r;
    endfunction

    // Line byte positions touched by a word write.
    function automatic logic [31:0] byte_mask(
        input logic [2:0] word,
        input logic [3:0] be
    );
        logic [31:0] m;
        m = 32'd0;
        m[4*int'(word) +: 4] = be;
        return m;
    endfunction

    // FSM and pending request
    state_t        state_q, state_d;
    logic          pend_q, pend_d;
    logic          p_we_q, p_we_d;
    logic [28:0]   p_line_q, p_line_d;
    logic [2:0]    p_word_q, p_word_d;
    logic [3:0]    p_be_q, p_be_d;
    logic [31:0]   p_data_q, p_data_d;
    // Write-combining buffer
    logic [28:0]   wtag_q, wtag_d;
    logic [255:0]  wdata_q, wdata_d;
    logic [31:0]   wvalid_q, wvalid_d;
    logic          dirty_q, dirty_d;
    // Read line cache
    logic [28:0]   ctag_q, ctag_d;
    logic [255:0]  cdata_q, cdata_d;
    logic          cvalid_q, cvalid_d;
    // Auto-flush idle counter
    logic [31:0]   cnt_q, cnt_d;
    // Registered outputs
    logic          srd_q, srd_d;
    logic          swr_q, swr_d;
    logic [28:0]   sa_q, sa_d;
    logic [31:0]   smsk_q, smsk_d;
    logic          rdy_q, rdy_d;
    logic [31:0]   rdata_q, rdata_d;

    // Request being acted on: live bus inputs in IDLE, latched copy otherwise
    logic          m_we_s;
    logic [28:0]   m_line_s;
    logic [2:0]    m_word_s;
    logic [3:0]    m_be_s;
    logic [31:0]   m_data_s;
    logic          do_merge_s;
    logic          start_flush_s;
    logic          unused_s;

    assign unused_s = ^{IO_Address[31:30], IO_Address[1:0], IO_Read_Strobe};

    // Select the request fields that the current state operates on.
    always_comb begin
        if (state_q == S_IDLE) begin
            m_we_s   = IO_Write_Strobe;
            m_line_s = {page, IO_Address[29:5]};
            m_word_s = IO_Address[4:2];
            m_be_s   = IO_Byte_Enable;
            m_data_s = IO_Write_Data;
        end else begin
            m_we_s   = p_we_q;
            m_line_s = p_line_q;
            m_word_s = p_word_q;
            m_be_s   = p_be_q;
            m_data_s = p_data_q;
        end
    end

    // Next-state, buffer/cache update and output computation.
    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        p_we_d        = p_we_q;
        p_line_d      = p_line_q;
        p_word_d      = p_word_q;
        p_be_d        = p_be_q;
        p_data_d      = p_data_q;
        wtag_d        = wtag_q;
        wdata_d       = wdata_q;
        wvalid_d      = wvalid_q;
        ctag_d        = ctag_q;
        cdata_d       = cdata_q;
        cvalid_d      = cvalid_q;
        cnt_d         = cnt_q;
        srd_d         = srd_q;
        swr_d         = swr_q;
        sa_d          = sa_q;
        smsk_d        = smsk_q;
        rdy_d         = 1'b0;
        rdata_d       = 32'd0;
        do_merge_s    = 1'b0;
        start_flush_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (IO_Addr_Strobe) begin
                    // A new strobe always wins over an expiring idle counter.
                    cnt_d    = 32'd0;
                    pend_d   = 1'b1;
                    p_we_d   = m_we_s;
                    p_line_d = m_line_s;
                    p_word_d = m_word_s;
                    p_be_d   = m_be_s;
                    p_data_d = m_data_s;
                    if (m_we_s) begin
                        if (!dirty_q || (wtag_q == m_line_s)) begin
                            do_merge_s = 1'b1;
                            rdy_d      = 1'b1;
                            state_d    = S_RESP;
                        end else begin
                            start_flush_s = 1'b1;
                        end
                    end else begin
                        if (cvalid_q && (ctag_q == m_line_s)) begin
                            rdy_d   = 1'b1;
                            rdata_d = cdata_q[32*int'(m_word_s) +: 32];
                            state_d = S_RESP;
                        end else if (dirty_q) begin
                            // Flush first so the fill sees any buffered bytes.
                            start_flush_s = 1'b1;
                        end else begin
                            srd_d   = 1'b1;
                            sa_d    = m_line_s;
                            state_d = S_FILL;
                        end
                    end
                end else if (dirty_q && (FLUSH_IDLE != 32'd0)) begin
                    if ((cnt_q + 32'd1) == FLUSH_IDLE) begin
                        cnt_d         = 32'd0;
                        start_flush_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end else begin
                    cnt_d = 32'd0;
                end
            end

            S_FLUSH: begin
                if (srdy) begin
                    swr_d    = 1'b0;
                    smsk_d   = 32'd0;
                    wvalid_d = 32'd0;
                    if (pend_q && p_we_q) begin
                        do_merge_s = 1'b1;
                        sa_d       = 29'd0;
                        rdy_d      = 1'b1;
                        state_d    = S_RESP;
                    end else if (pend_q) begin
                        // Read that missed: the cache cannot have changed, so fill.
                        srd_d   = 1'b1;
                        sa_d    = p_line_q;
                        state_d = S_FILL;
                    end else begin
                        // Auto-flush with no request behind it.
                        sa_d    = 29'd0;
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_FLUSH;
                end
            end

            S_FILL: begin
                if (srdy) begin
                    srd_d    = 1'b0;
                    sa_d     = 29'd0;
                    cdata_d  = srdat;
                    ctag_d   = p_line_q;
                    cvalid_d = 1'b1;
                    rdy_d    = 1'b1;
                    rdata_d  = srdat[32*int'(p_word_q) +: 32];
                    state_d  = S_RESP;
                end else begin
                    state_d = S_FILL;
                end
            end

            S_RESP: begin
                pend_d  = 1'b0;
                cnt_d   = 32'd0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_flush_s) begin
            swr_d   = 1'b1;
            sa_d    = wtag_q;
            smsk_d  = ~wvalid_q;
            state_d = S_FLUSH;
        end else begin
            swr_d = swr_d;
        end

        if (do_merge_s) begin
            wtag_d   = m_line_s;
            wdata_d  = merge_line(wdata_q, m_word_s, m_be_s, m_data_s);
            wvalid_d = wvalid_d | byte_mask(m_word_s, m_be_s);
            if (cvalid_q && (ctag_q == m_line_s)) begin
                cdata_d = merge_line(cdata_q, m_word_s, m_be_s, m_data_s);
            end else begin
                cdata_d = cdata_d;
            end
        end else begin
            wdata_d = wdata_d;
        end

        dirty_d = |wvalid_d;
    end

    // State, buffer, cache and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pend_q   <= 1'b0;
            p_we_q   <= 1'b0;
            p_line_q <= 29'd0;
            p_word_q <= 3'd0;
            p_be_q   <= 4'd0;
            p_data_q <= 32'd0;
            wtag_q   <= 29'd0;
            wdata_q  <= 256'd0;
            wvalid_q <= 32'd0;
            dirty_q  <= 1'b0;
            ctag_q   <= 29'd0;
            cdata_q  <= 256'd0;
            cvalid_q <= 1'b0;
            cnt_q    <= 32'd0;
            srd_q    <= 1'b0;
            swr_q    <= 1'b0;
            sa_q     <= 29'd0;
            smsk_q   <= 32'd0;
            rdy_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            p_we_q   <= p_we_d;
            p_line_q <= p_line_d;
            p_word_q <= p_word_d;
            p_be_q   <= p_be_d;
            p_data_q <= p_data_d;
            wtag_q   <= wtag_d;
            wdata_q  <= wdata_d;
            wvalid_q <= wvalid_d;
            dirty_q  <= dirty_d;
            ctag_q   <= ctag_d;
            cdata_q  <= cdata_d;
            cvalid_q <= cvalid_d;
            cnt_q    <= cnt_d;
            srd_q    <= srd_d;
            swr_q    <= swr_d;
            sa_q     <= sa_d;
            smsk_q   <= smsk_d;
            rdy_q    <= rdy_d;
            rdata_q  <= rdata_d;
        end
    end

    assign IO_Ready     = rdy_q;
    assign IO_Read_Data = rdata_q;
    assign srd          = srd_q;
    assign swr          = swr_q;
    assign sa           = sa_q;
    assign swdat        = wdata_q;
    assign smsk         = smsk_q;

endmodule

// File: tb/tb_mcs_line_bridge.sv
// Testbench for mcs_line_bridge: directed scenarios plus a randomized run
// against a DDR memory model, a byte-level golden CPU memory and an abstract
// model of the buffer/cache occupancy.
module tb_mcs_line_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic         IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe;
    logic [31:0]  IO_Address;
    logic [3:0]   IO_Byte_Enable;
    logic [31:0]  IO_Write_Data;
    logic [31:0]  IO_Read_Data;
    logic         IO_Ready;
    logic [3:0]   page;
    logic         srd, swr;
    logic [28:0]  sa;
    logic [255:0] swdat;
    logic [31:0]  smsk;
    logic [255:0] srdat;
    logic         srdy;

    int checks = 0;
    int failures = 0;

    // DDR model and golden CPU view, both keyed by line address
    logic [255:0] mem  [int];
    logic [255:0] gold [int];

    bit           svc_en;
    int           fixed_lat;
    bit           busy;
    int           wait_left;
    logic [28:0]  hold_sa;
    logic [255:0] hold_w;
    logic [31:0]  hold_m;
    int           tx_wr, tx_rd, viol;
    logic [28:0]  last_wr_sa, last_rd_sa;
    logic [255:0] last_wr_dat;
    logic [31:0]  last_wr_msk;

    always #5 clk = ~clk;

    mcs_line_bridge #(.FLUSH_IDLE(64)) dut (
        .clk(clk), .rst(rst),
        .IO_Addr_Strobe(IO_Addr_Strobe), .IO_Read_Strobe(IO_Read_Strobe),
        .IO_Write_Strobe(IO_Write_Strobe), .IO_Address(IO_Address),
        .IO_Byte_Enable(IO_Byte_Enable), .IO_Write_Data(IO_Write_Data),
        .IO_Read_Data(IO_Read_Data), .IO_Ready(IO_Ready), .page(page),
        .srd(srd), .swr(swr), .sa(sa), .swdat(swdat), .smsk(smsk),
        .srdat(srdat), .srdy(srdy)
    );

    function automatic logic [255:0] init_line(input int a);
        logic [255:0] r;
        logic [31:0]  t;
        for (int j = 0; j < 8; j++) begin
            t = 32'h9E3779B9 * (a * 8 + j + 1);
            r[32*j +: 32] = t;
        end
        return r;
    endfunction

    function automatic logic [255:0] mem_line(input int a);
        return mem.exists(a) ? mem[a] : init_line(a);
    endfunction

    function automatic logic [255:0] gold_line(input int a);
        return gold.exists(a) ? gold[a] : init_line(a);
    endfunction

    function automatic logic [31:0] exp_word(input int a, input int w);
        logic [255:0] g;
        g = gold_line(a);
        return g[32*w +: 32];
    endfunction

    // DDR responder, called once per negedge: answers srd/swr after a latency.
    task automatic service();
        logic [255:0] ln;
        srdy = 1'b0;
        if (svc_en && (srd || swr)) begin
            if (srd && swr) viol++;
            if (!busy) begin
                busy = 1'b1;
                hold_sa = sa; hold_w = swdat; hold_m = smsk;
                wait_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end else if (sa !== hold_sa || swdat !== hold_w || smsk !== hold_m) begin
                viol++;
            end
            if (wait_left == 0) begin
                srdy = 1'b1;
                busy = 1'b0;
                if (swr) begin
                    ln = mem_line(int'(sa));
                    for (int b = 0; b < 32; b++) if (!smsk[b]) ln[8*b +: 8] = swdat[8*b +: 8];
                    mem[int'(sa)] = ln;
                    tx_wr++;
                    last_wr_sa = sa; last_wr_dat = swdat; last_wr_msk = smsk;
                end else begin
                    srdat = mem_line(int'(sa));
                    tx_rd++;
                    last_rd_sa = sa;
                end
            end else begin
                wait_left--;
            end
        end
    endtask

    // One CPU access; returns data, cycles from strobe to IO_Ready and line traffic.
    task automatic do_access(input bit we, input logic [3:0] pg, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wd,
                             output logic [31:0] rd, output int cyc, output int nw,
                             output int nr, output bit tmo);
        int w0, r0, line, w;
        logic [255:0] g;
        w0 = tx_wr; r0 = tx_rd;
        line = int'({pg, addr[29:5]});
        w = int'(addr[4:2]);
        IO_Addr_Strobe = 1'b1; IO_Write_Strobe = we; IO_Read_Strobe = !we;
        IO_Address = addr; IO_Byte_Enable = be; IO_Write_Data = wd; page = pg;
        @(negedge clk);
        IO_Addr_Strobe = 1'b0; IO_Write_Strobe = 1'b0; IO_Read_Strobe = 1'b0;
        cyc = 1; tmo = 1'b1; rd = 32'd0;
        for (int i = 0; i < 400; i++) begin
            service();
            if (IO_Ready === 1'b1) begin
                rd = IO_Read_Data; tmo = 1'b0;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        service();
        nw = tx_wr - w0; nr = tx_rd - r0;
        if (we) begin
            g = gold_line(line);
            for (int k = 0; k < 4; k++) if (be[k]) g[32*w + 8*k +: 8] = wd[8*k +: 8];
            gold[line] = g;
        end
    endtask

    // Idle n cycles, then let any line transaction in flight complete.
    task automatic idle(input int n);
        for (int i = 0; i < n + 100; i++) begin
            service();
            if (i >= n && !busy && !srd && !swr) break;
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; busy = 1'b0; srdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (IO_Ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", IO_Ready); end
        checks++; if (srd !== 1'b0 || swr !== 1'b0) begin failures++; $display("FAIL reset_srd_swr got=%b%b exp=00", srd, swr); end
        checks++; if (sa !== 29'd0) begin failures++; $display("FAIL reset_sa got=%h exp=0", sa); end
        checks++; if (smsk !== 32'd0) begin failures++; $display("FAIL reset_smsk got=%h exp=0", smsk); end
        checks++; if (swdat !== 256'd0) begin failures++; $display("FAIL reset_swdat got=%h exp=0", swdat); end
        checks++; if (IO_Read_Data !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", IO_Read_Data); end
    endtask

    task automatic test_flush_on_conflict();
        logic [31:0] rd; int cyc, nw, nr; bit tmo;
        logic [31:0] dw;
        fixed_lat = 0;
        do_access(1'b1, 4'd0, 32'h0000_0004, 4'hF, 32'hA5A5_A5A5, rd, cyc, nw, nr, tmo);
        checks++; if (tmo || cyc !== 1 || nw !== 0 || nr !== 0) begin failures++; $display("FAIL conf_write cyc=%0d nw=%0d nr=%0d tmo=%0d exp cyc=1 nw=0 nr=0", cyc, nw, nr, tmo); end
        do_access(1'b0, 4'd0, 32'h0000_0020, 4'hF, 32'd0, rd, cyc, nw, nr, tmo);
        dw = last_wr_dat[63:32];
        checks++; if (nw !== 1 || last_wr_sa !== 29'd0) begin failures++; $display("FAIL conf_flush nw=%0d sa=%h exp nw=1 sa=0", nw, last_wr_sa); end
        checks++; if (dw !== 32'hA5A5_A5A5) begin failures++; $display("FAIL conf_swdat got=%h exp=a5a5a5a5", dw); end
        checks++; if (last_wr_msk !== 32'hFFFF_FF0F) begin failures++; $display("FAIL conf_smsk got=%h exp=ffffff0f", last_wr_msk); end
        checks++; if (nr !== 1 || last_rd_sa !== 29'd1) begin failures++; $display("FAIL conf_fill nr=%0d sa=%h exp nr=1 sa=1", nr, last_rd_sa); end
        checks++; if (tmo || cyc !== 3) begin failures++; $display("FAIL conf_latency got=%0d exp=3", cyc); end
        checks++; if (rd !== exp_word(1, 0)) begin failures++; $display("FAIL conf_rdata got=%h exp=%h", rd, exp_word(1, 0)); end
    endtask

    task automatic test_combine();
        logic [31:0] rd, d1, d2; int cyc, nw, nr, w0; bit tmo;
        fixed_lat = 1;
        d1 = $urandom; d2 = $urandom;
        do_access(1'b1, 4'd0, 32'h0000_0010, 4'h1, d1, rd, cyc, nw, nr, tmo);
        checks++; if (tmo || cyc !== 1 || nw !== 0) begin failures++; $display("FAIL comb_w1 cyc=%0d nw=%0d exp cyc=1 nw=0", cyc, nw); end
        do_access(1'b1, 4'd0, 32'h0000_0010, 4'h2, d2, rd, cyc, nw, nr, tmo);
        checks++; if (tmo || cyc !== 1 || nw !== 0) begin failures++; $display("FAIL comb_w2 cyc=%0d nw=%0d exp cyc=1 nw=0", cyc, nw); end
        w0 = tx_wr;
        idle(70);
        checks++; if (tx_wr - w0 !== 1 || last_wr_sa !== 29'd0) begin failures++; $display("FAIL comb_single_flush n=%0d sa=%h exp n=1 sa=0", tx_wr - w0, last_wr_sa); end
        checks++; if (last_wr_msk !== 32'hFFFC_FFFF) begin failures++; $display("FAIL comb_smsk got=%h exp=fffcffff", last_wr_msk); end
        checks++; if (last_wr_dat[143:128] !== {d2[15:8], d1[7:0]}) begin failures++; $display("FAIL comb_data got=%h exp=%h", last_wr_dat[143:128], {d2[15:8], d1[7:0]}); end
    endtask

    task automatic test_read_hit();
        logic [31:0] rd; int cyc, nw, nr; bit tmo;
        logic [255:0] l;
        l = mem_line(0);  l[127:96] = 32'h1234_5678; mem[0] = l;
        l = gold_line(0); l[127:96] = 32'h1234_5678; gold[0] = l;
        do_access(1'b0, 4'd0, 32'h0000_0000, 4'hF, 32'd0, rd, cyc, nw, nr, tmo);
        checks++; if (tmo || nr !== 1 || cyc !== 3) begin failures++; $display("FAIL hit_fill nr=%0d cyc=%0d exp nr=1 cyc=3", nr, cyc); end
        do_access(1'b0, 4'd0, 32'h0000_000C, 4'hF, 32'd0, rd, cyc, nw, nr, tmo);
        checks++; if (tmo || nr !== 0 || cyc !== 1) begin failures++; $display("FAIL hit_latency nr=%0d cyc=%0d exp nr=0 cyc=1", nr, cyc); end
        checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL hit_data got=%h exp=12345678", rd); end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd; int cyc, nw, nr; bit tmo;
        do_access(1'b1, 4'd0, 32'h0000_000C, 4'h8, 32'hFF00_0000, rd, cyc, nw, nr, tmo);
        checks++; if (tmo || cyc !== 1 || nw !== 0 || nr !== 0) begin failures++; $display("FAIL whit_write cyc=%0d nw=%0d nr=%0d exp 1/0/0", cyc, nw, nr); end
        do_access(1'b0, 4'd0, 32'h0000_000C, 4'hF, 32'd0, rd, cyc, nw, nr, tmo);
        checks++; if (tmo || cyc !== 1 || nw !== 0 || nr !== 0) begin failures++; $display("FAIL whit_read cyc=%0d nw=%0d nr=%0d exp 1/0/0", cyc, nw, nr); end
        checks++; if (rd !== 32'hFF34_5678) begin failures++; $display("FAIL whit_data got=%h exp=ff345678", rd); end
    endtask

    task automatic test_auto_flush();
        logic [31:0] rd; int cyc, nw, nr, cnt, rcnt, w0; bit tmo, seen;
        do_access(1'b1, 4'd0, 32'h0000_0008, 4'hF, $urandom, rd, cyc, nw, nr, tmo);
        checks++; if (tmo || cyc !== 1 || nw !== 0) begin failures++; $display("FAIL auto_write cyc=%0d nw=%0d exp 1/0", cyc, nw); end
        w0 = tx_wr; cnt = 0; rcnt = 0; seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (swr === 1'b1) begin seen = 1'b1; break; end
            if (IO_Ready === 1'b1) rcnt++;
            cnt++;
            @(negedge clk);
        end
        checks++; if (!seen || cnt !== 64) begin failures++; $display("FAIL auto_idle_cycles got=%0d seen=%0d exp=64", cnt, seen); end
        idle(0);
        checks++; if (rcnt !== 0 || IO_Ready !== 1'b0) begin failures++; $display("FAIL auto_no_ready got=%0d exp=0", rcnt); end
        checks++; if (tx_wr - w0 !== 1 || last_wr_sa !== 29'd0) begin failures++; $display("FAIL auto_flush n=%0d sa=%h exp n=1 sa=0", tx_wr - w0, last_wr_sa); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int cyc, nw, nr, rcnt; bit tmo, seen;
        svc_en = 1'b0; seen = 1'b0; rcnt = 0;
        IO_Addr_Strobe = 1'b1; IO_Read_Strobe = 1'b1; IO_Address = 32'h0000_00A0; page = 4'd0;
        @(negedge clk);
        IO_Addr_Strobe = 1'b0; IO_Read_Strobe = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (srd === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin failures++; $display("FAIL rstmid_srd_seen got=0 exp=1"); end
        #2 rst = 1'b1;
        #1;
        checks++; if (srd !== 1'b0) begin failures++; $display("FAIL rstmid_srd_drop got=%b exp=0", srd); end
        @(negedge clk);
        rst = 1'b0; svc_en = 1'b1; busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (IO_Ready === 1'b1) rcnt++;
            @(negedge clk);
        end
        checks++; if (rcnt !== 0) begin failures++; $display("FAIL rstmid_no_ready got=%0d exp=0", rcnt); end
        do_access(1'b0, 4'd0, 32'h0000_000C, 4'hF, 32'd0, rd, cyc, nw, nr, tmo);
        checks++; if (tmo || nr !== 1) begin failures++; $display("FAIL rstmid_miss nr=%0d exp=1", nr); end
        checks++; if (rd !== exp_word(0, 3)) begin failures++; $display("FAIL rstmid_data got=%h exp=%h", rd, exp_word(0, 3)); end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wd; logic [3:0] be, pg;
        int cyc, nw, nr, line, w, g, ln, ew, er;
        bit tmo, we, hit, m_dirty, m_cvalid;
        int m_wtag, m_ctag;
        logic [255:0] a, b;
        apply_reset();
        fixed_lat = -1; viol = 0;
        m_dirty = 1'b0; m_cvalid = 1'b0; m_wtag = 0; m_ctag = 0;
        for (int it = 0; it < 200; it++) begin
            we   = 1'($urandom_range(0, 1));
            pg   = 4'($urandom_range(0, 1));
            ln   = int'($urandom_range(0, 3));
            w    = int'($urandom_range(0, 7));
            addr = 32'(ln * 32 + w * 4 + int'($urandom_range(0, 3)));
            be   = 4'($urandom_range(1, 15));
            wd   = $urandom;
            line = int'(pg) * 33554432 + ln;
            if (we) begin
                ew = (m_dirty && m_wtag != line) ? 1 : 0; er = 0;
                m_dirty = 1'b1; m_wtag = line;
            end else begin
                hit = m_cvalid && (m_ctag == line);
                er = hit ? 0 : 1;
                ew = (!hit && m_dirty) ? 1 : 0;
                if (!hit) begin m_dirty = 1'b0; m_cvalid = 1'b1; m_ctag = line; end
            end
            do_access(we, pg, addr, be, wd, rd, cyc, nw, nr, tmo);
            checks++; if (tmo) begin failures++; $display("FAIL rnd_timeout it=%0d got=timeout exp=ready", it); end
            checks++; if (nw !== ew || nr !== er) begin failures++; $display("FAIL rnd_traffic it=%0d got wr=%0d rd=%0d exp wr=%0d rd=%0d", it, nw, nr, ew, er); end
            if (ew == 0 && er == 0) begin
                checks++; if (cyc !== 1) begin failures++; $display("FAIL rnd_latency it=%0d got=%0d exp=1", it, cyc); end
            end
            if (!we) begin
                checks++; if (rd !== exp_word(line, w)) begin failures++; $display("FAIL rnd_rdata it=%0d got=%h exp=%h", it, rd, exp_word(line, w)); end
            end
            g = ($urandom_range(0, 9) == 0) ? 70 : int'($urandom_range(0, 3));
            idle(g);
            if (g == 70) m_dirty = 1'b0;
        end
        idle(70);
        checks++; if (viol !== 0) begin failures++; $display("FAIL rnd_protocol got=%0d exp=0", viol); end
        for (int p = 0; p < 2; p++) begin
            for (int l = 0; l < 4; l++) begin
                a = mem_line(p * 33554432 + l); b = gold_line(p * 33554432 + l);
                checks++; if (a !== b) begin failures++; $display("FAIL rnd_memory line=%0d.%0d got=%h exp=%h", p, l, a, b); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; svc_en = 1'b1; fixed_lat = 0; busy = 1'b0; wait_left = 0;
        tx_wr = 0; tx_rd = 0; viol = 0;
        IO_Addr_Strobe = 1'b0; IO_Read_Strobe = 1'b0; IO_Write_Strobe = 1'b0;
        IO_Address = 32'd0; IO_Byte_Enable = 4'd0; IO_Write_Data = 32'd0; page = 4'd0;
        srdat = 256'd0; srdy = 1'b0;
        last_wr_sa = 29'd0; last_rd_sa = 29'd0; last_wr_dat = 256'd0; last_wr_msk = 32'd0;
        test_reset();
        test_flush_on_conflict();
        test_combine();
        test_read_hit();
        test_write_hit();
        test_auto_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
